// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic note-to-voice allocator with retrigger, lowest-free and LRU-steal policy.
// Each event is scanned over NUM_VOICES cycles and applied in one more, so the block is busy N+1 cycles.
module voice_alloc #(
   parameter int NUM_VOICES = 4,
   parameter int IDX_BW     = 2
) (
   input  logic                    clk_i,
   input  logic                    nrst_i,
   input  logic                    evValid_i,
   output logic                    evReady_o,
   input  logic                    evNoteOn_i,
   input  logic [7:0]              evNote_i,
   input  logic                    allOff_i,
   output logic [8*NUM_VOICES-1:0] voiceNote_o,
   output logic [NUM_VOICES-1:0]   voiceEnable_o,
   output logic [NUM_VOICES-1:0]   voicePhaseRst_o,
   output logic [IDX_BW:0]         activeCnt_o
);
   typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
   state_t                r_state;
   logic [IDX_BW-1:0]     r_scan_idx, r_match_idx, r_free_idx, r_old_idx, r_old_age;
   logic                  r_match_found, r_free_found, r_old_found, r_ev_on;
   logic [7:0]            r_ev_note;
   logic [7:0]            r_note [NUM_VOICES];
   logic [IDX_BW-1:0]     r_age [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_en, r_prst;
   logic [IDX_BW:0]       r_cnt;
   logic [7:0]            w_note_nx [NUM_VOICES];
   logic [IDX_BW-1:0]     w_age_nx [NUM_VOICES];
   logic [NUM_VOICES-1:0] w_en_nx, w_prst_nx;
   logic [IDX_BW:0]       w_cnt_nx;
   logic [IDX_BW-1:0]     w_tgt;
   logic                  w_apply, w_hit;
   assign w_tgt   = r_match_found ? r_match_idx : (r_free_found ? r_free_idx : r_old_idx);
   // notes above 127 run the full sequence but never touch the voices
   assign w_apply = (r_state == APPLY) && !r_ev_note[7];
   assign w_hit   = r_en[r_scan_idx] && (r_note[r_scan_idx] == r_ev_note);
   always_comb begin
      w_note_nx = r_note;
      w_age_nx  = r_age;
      w_en_nx   = r_en;
      w_prst_nx = '0;
      w_cnt_nx  = '0;
      if (allOff_i)
         w_en_nx = '0;
      else if (w_apply && r_ev_on) begin
         w_note_nx[w_tgt] = r_ev_note;
         w_en_nx[w_tgt]   = 1'b1;
         w_prst_nx[w_tgt] = 1'b1;
         for (int i = 0; i < NUM_VOICES; i++)
            w_age_nx[i] = (IDX_BW'(i) == w_tgt) ? '0 :
                          (r_age[i] < r_age[w_tgt]) ? r_age[i] + 1'b1 : r_age[i];
      end else if (w_apply) begin
         for (int i = 0; i < NUM_VOICES; i++)
            if (r_en[i] && r_note[i] == r_ev_note) w_en_nx[i] = 1'b0;
      end
      for (int i = 0; i < NUM_VOICES; i++)
         w_cnt_nx = w_cnt_nx + (IDX_BW+1)'(w_en_nx[i]);
   end
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_state       <= IDLE;
         r_scan_idx    <= '0;
         r_match_idx   <= '0;
         r_free_idx    <= '0;
         r_old_idx     <= '0;
         r_old_age     <= '0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_old_found   <= 1'b0;
         r_ev_on       <= 1'b0;
         r_ev_note     <= '0;
         r_en          <= '0;
         r_prst        <= '0;
         r_cnt         <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            r_note[i] <= '0;
            r_age[i]  <= IDX_BW'(i);
         end
      end else begin
         r_note <= w_note_nx;
         r_age  <= w_age_nx;
         r_en   <= w_en_nx;
         r_prst <= w_prst_nx;
         r_cnt  <= w_cnt_nx;
         if (allOff_i)
            r_state <= IDLE;
         else case (r_state)
            IDLE: if (evValid_i) begin
               r_state       <= SCAN;
               r_ev_on       <= evNoteOn_i;
               r_ev_note     <= evNote_i;
               r_scan_idx    <= '0;
               r_match_found <= 1'b0;
               r_free_found  <= 1'b0;
               r_old_found   <= 1'b0;
            end
            SCAN: begin
               if (w_hit && !r_match_found) begin
                  r_match_found <= 1'b1;
                  r_match_idx   <= r_scan_idx;
               end
               if (!r_en[r_scan_idx] && !r_free_found) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_scan_idx;
               end
               if (r_en[r_scan_idx] && (!r_old_found || r_age[r_scan_idx] > r_old_age)) begin
                  r_old_found <= 1'b1;
                  r_old_idx   <= r_scan_idx;
                  r_old_age   <= r_age[r_scan_idx];
               end
               r_scan_idx <= r_scan_idx + 1'b1;
               if (r_scan_idx == IDX_BW'(NUM_VOICES-1)) r_state <= APPLY;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign evReady_o       = (r_state == IDLE);
   assign voiceEnable_o   = r_en;
   assign voicePhaseRst_o = r_prst;
   assign activeCnt_o     = r_cnt;
   genvar g;
   for (g = 0; g < NUM_VOICES; g++) begin : g_note
      assign voiceNote_o[8*g +: 8] = r_note[g];
   end
endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed bench for voice_alloc with an event-level allocation model
// (LRU kept as a recency queue) compared every cycle, plus literal spot checks.
module tb_voice_alloc;
   localparam int N = 4;
   logic           clk_i = 1'b0, nrst_i = 1'b0, evValid_i = 1'b0, evNoteOn_i = 1'b0, allOff_i = 1'b0;
   logic [7:0]     evNote_i = '0;
   logic           evReady_o;
   logic [8*N-1:0] voiceNote_o;
   logic [N-1:0]   voiceEnable_o, voicePhaseRst_o;
   logic [2:0]     activeCnt_o;
   int             errors = 0, checks = 0;

   always #5 clk_i = ~clk_i;

   voice_alloc #(.NUM_VOICES(N), .IDX_BW(2)) dut (
      .clk_i(clk_i), .nrst_i(nrst_i), .evValid_i(evValid_i), .evReady_o(evReady_o),
      .evNoteOn_i(evNoteOn_i), .evNote_i(evNote_i), .allOff_i(allOff_i),
      .voiceNote_o(voiceNote_o), .voiceEnable_o(voiceEnable_o),
      .voicePhaseRst_o(voicePhaseRst_o), .activeCnt_o(activeCnt_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // event-level model: voices as arrays, recency as a queue (front = newest)
   logic [7:0]     m_note [N];
   logic [N-1:0]   m_en = '0, m_prst = '0;
   int             m_busy = 0;
   logic           m_pon;
   logic [7:0]     m_pnote;
   int             lru[$];
   logic [8*N-1:0] xn;

   task model_apply();
      int t;
      t = -1;
      if (m_pnote > 8'd127) return;
      if (!m_pon) begin
         for (int i = 0; i < N; i++) if (m_en[i] && m_note[i] == m_pnote) m_en[i] = 1'b0;
         return;
      end
      for (int i = 0; i < N; i++) if (t < 0 && m_en[i] && m_note[i] == m_pnote) t = i;
      for (int i = 0; i < N; i++) if (t < 0 && !m_en[i]) t = i;
      for (int k = lru.size() - 1; k >= 0; k--) if (t < 0 && m_en[lru[k]]) t = lru[k];
      m_note[t] = m_pnote;
      m_en[t]   = 1'b1;
      m_prst[t] = 1'b1;
      for (int k = 0; k < lru.size(); k++) if (lru[k] == t) begin lru.delete(k); break; end
      lru.push_front(t);
   endtask

   always @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         m_busy = 0; m_en = '0; m_prst = '0;
         lru.delete();
         for (int i = 0; i < N; i++) begin m_note[i] = '0; lru.push_back(i); end
      end else begin
         m_prst = '0;
         if (allOff_i) begin m_en = '0; m_busy = 0; end
         else if (m_busy > 0) begin m_busy--; if (m_busy == 0) model_apply(); end
         else if (evValid_i) begin m_busy = N + 1; m_pon = evNoteOn_i; m_pnote = evNote_i; end
      end
   end

   always @(negedge clk_i) begin
      for (int i = 0; i < N; i++) xn[8*i +: 8] = m_note[i];
      chk("ready", 32'(evReady_o), 32'(m_busy == 0));
      chk("notes", 32'(voiceNote_o), 32'(xn));
      chk("enable", 32'(voiceEnable_o), 32'(m_en));
      chk("phase", 32'(voicePhaseRst_o), 32'(m_prst));
      chk("count", 32'(activeCnt_o), 32'($countones(m_en)));
   end

   task automatic send(input logic on, input logic [7:0] note, output int busy);
      evValid_i = 1'b1; evNoteOn_i = on; evNote_i = note;
      @(negedge clk_i);
      evValid_i = 1'b0;
      busy = 0;
      while (!evReady_o && busy < 50) begin busy++; @(negedge clk_i); end
   endtask

   task automatic all_off();
      allOff_i = 1'b1;
      @(negedge clk_i);
      allOff_i = 1'b0;
   endtask

   initial begin
      int b;
      logic [31:0] pre_n;
      logic [3:0]  pre_e;
      repeat (2) @(negedge clk_i);
      chk("rst_ready", 32'(evReady_o), 32'h1);
      chk("rst_en", 32'(voiceEnable_o), 32'h0);
      chk("rst_cnt", 32'(activeCnt_o), 32'h0);
      nrst_i = 1'b1;
      @(negedge clk_i);
      send(1'b1, 8'd60, b);
      chk("busy60", 32'(b), 32'd5);
      chk("n0_60", 32'(voiceNote_o[7:0]), 32'd60);
      chk("en_0001", 32'(voiceEnable_o), 32'h1);
      chk("ph_0001", 32'(voicePhaseRst_o), 32'h1);
      chk("cnt1", 32'(activeCnt_o), 32'd1);
      @(negedge clk_i);
      chk("ph_clear", 32'(voicePhaseRst_o), 32'h0);
      send(1'b1, 8'd64, b); send(1'b1, 8'd67, b); send(1'b1, 8'd72, b);
      chk("en_full", 32'(voiceEnable_o), 32'hF);
      send(1'b1, 8'd76, b);
      chk("steal_n", 32'(voiceNote_o), {8'd72, 8'd67, 8'd64, 8'd76});
      chk("steal_ph", 32'(voicePhaseRst_o), 32'h1);
      chk("steal_cnt", 32'(activeCnt_o), 32'd4);
      all_off();
      send(1'b1, 8'd60, b); send(1'b1, 8'd60, b);
      chk("retrig_ph", 32'(voicePhaseRst_o), 32'h1);
      chk("retrig_en", 32'(voiceEnable_o), 32'h1);
      chk("retrig_cnt", 32'(activeCnt_o), 32'd1);
      send(1'b1, 8'd64, b);
      send(1'b0, 8'd60, b);
      chk("off_en", 32'(voiceEnable_o), 32'h2);
      chk("off_n0", 32'(voiceNote_o[7:0]), 32'd60);
      chk("off_ph", 32'(voicePhaseRst_o), 32'h0);
      send(1'b0, 8'd99, b);
      chk("off99_en", 32'(voiceEnable_o), 32'h2);
      send(1'b1, 8'd65, b);
      chk("free_n0", 32'(voiceNote_o[7:0]), 32'd65);
      chk("free_en", 32'(voiceEnable_o), 32'h3);
      all_off();
      send(1'b1, 8'd60, b); send(1'b1, 8'd64, b); send(1'b1, 8'd67, b);
      chk("three", 32'(activeCnt_o), 32'd3);
      evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 8'd70;
      @(negedge clk_i);
      evValid_i = 1'b0; allOff_i = 1'b1;
      @(negedge clk_i);
      allOff_i = 1'b0;
      chk("abort_en", 32'(voiceEnable_o), 32'h0);
      chk("abort_cnt", 32'(activeCnt_o), 32'h0);
      chk("abort_rdy", 32'(evReady_o), 32'h1);
      chk("abort_ph", 32'(voicePhaseRst_o), 32'h0);
      repeat (8) begin
         @(negedge clk_i);
         for (int i = 0; i < N; i++) chk("no70", 32'(voiceNote_o[8*i +: 8] == 8'd70), 32'h0);
         chk("abort_ph2", 32'(voicePhaseRst_o), 32'h0);
      end
      send(1'b1, 8'd61, b);
      pre_n = voiceNote_o; pre_e = voiceEnable_o;
      @(negedge clk_i);
      send(1'b1, 8'd200, b);
      chk("oor_busy", 32'(b), 32'd5);
      chk("oor_n", 32'(voiceNote_o), pre_n);
      chk("oor_en", 32'(voiceEnable_o), 32'(pre_e));
      chk("oor_ph", 32'(voicePhaseRst_o), 32'h0);
      evValid_i = 1'b1; evNoteOn_i = 1'b1; evNote_i = 8'd50;
      @(negedge clk_i);
      evValid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      #2 nrst_i = 1'b0;
      #1;
      chk("mid_rst_n", 32'(voiceNote_o), 32'h0);
      chk("mid_rst_en", 32'(voiceEnable_o), 32'h0);
      chk("mid_rst_cnt", 32'(activeCnt_o), 32'h0);
      chk("mid_rst_rdy", 32'(evReady_o), 32'h1);
      @(negedge clk_i);
      nrst_i = 1'b1;
      @(negedge clk_i);
      send(1'b1, 8'd60, b); send(1'b1, 8'd64, b); send(1'b1, 8'd67, b); send(1'b1, 8'd72, b);
      send(1'b1, 8'd60, b);
      chk("lru_retrig", 32'(voicePhaseRst_o), 32'h1);
      send(1'b1, 8'd80, b);
      chk("lru_steal_n", 32'(voiceNote_o), {8'd72, 8'd67, 8'd80, 8'd60});
      chk("lru_steal_ph", 32'(voicePhaseRst_o), 32'h2);
      repeat (3) @(negedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
